io_bus_master: RTL and testbench
================================

# io_bus_master

CPU-side initiator for the IO bus. It accepts single-word load/store requests from the CPU memory stage, decodes the target device from the address, drives `addr`/`ctrl`/`data` and grants the bus to exactly one device interface (LED/switch, etc.) through its `BG` input. It then completes the transfer with a one-cycle `ready` pulse. It is the other end of the device-side interface protocol: write data is latched by the device on the clock edge ending a granted write cycle, and read data is sampled from the device's registered output buffer at the end of a granted read cycle.

## Interface
Parameters:
- `N_DEV`, default 4: number of attached devices, one `bg` bit each.
- `DEV_SEL_LSB`, default 12: lowest address bit of the device-select field.
- `DEV_SEL_W`, default 4: width of the device-select field.
- `ACCESS_CYCLES`, default 1: cycles `bg` is held per transfer; legal range 1..15.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  1: CPU request; sampled only in IDLE.
- `we`  in  1: 1 = write, 0 = read.
- `cpu_addr`  in  `IO_BUS_WIDTH_ADDR`: target address.
- `wdata`  in  `IO_BUS_WIDTH_DATA`: write data.
- `ready`  out  1: one-cycle completion pulse.
- `err`  out  1: unmapped device; valid only with `ready`.
- `rdata`  out  `IO_BUS_WIDTH_DATA`: read result; held until the next read completes.
- `busy`  out  1: high in every state except IDLE.
- `addr`  out  `IO_BUS_WIDTH_ADDR`: IO bus address.
- `ctrl`  out  `IO_BUS_WIDTH_CTRL`: IO bus control.
- `data`  inout  `IO_BUS_WIDTH_DATA`: shared IO data bus.
- `bg`  out  `N_DEV`: one-hot bus grant; each bit drives one device's `BG`.

## Operation
- **Reset values.** `ready`=0, `err`=0, `rdata`=0, `busy`=0, `addr`=0, `ctrl`=0 with `ctrl[IO_BUS_CTRL_WE]`=`IO_CTRL_READ`, `bg`=0, `data`=Z. FSM enters IDLE.
- **FSM states.** IDLE, SETUP, ACCESS, DONE.
- **IDLE.**
  - If `req`=1, latch `we`, `cpu_addr`, `wdata`, and `dev = cpu_addr[DEV_SEL_LSB+DEV_SEL_W-1:DEV_SEL_LSB]`.
  - If `dev` < `N_DEV`, go to SETUP.
  - Otherwise set `err`=1 and go directly to DONE; `bg` is never asserted.
- **SETUP** (1 cycle).
  - `addr` = latched address.
  - `ctrl[IO_BUS_CTRL_WE]` = `IO_CTRL_WRITE` or `IO_CTRL_READ`; all other `ctrl` bits are 0.
  - `bg`=0.
  - For a write, `data` is driven with the latched `wdata`.
  - Go to ACCESS and load the counter with `ACCESS_CYCLES-1`.
- **ACCESS.**
  - `bg[dev]`=1, all other `bg` bits 0; `addr`/`ctrl`/`data` are unchanged from SETUP.
  - Counter decrements each cycle.
  - On the edge where the counter equals 0:
    - Read: capture `data` into `rdata`.
    - Write: the device latches `data` on this same edge.
  - Then go to DONE.
- **DONE** (1 cycle). `bg`=0, `ready`=1, `data`=Z, then go to IDLE. `err` is cleared on leaving DONE.
- **Data bus ownership.** `data` is driven only in SETUP/ACCESS of a write, and is Z at all other times. The master never drives during a read, so there is no contention with the device.
- **Request handling.**
  - `req` is ignored while `busy`=1.
  - A `req` held high through DONE is accepted again in the following IDLE cycle (a new transfer).
- **Read data.** `rdata` is unchanged by writes and error completions, except that an error read forces `rdata`=0.
- **Reset during a transfer.** Asserting reset mid-transfer aborts it immediately: all outputs return to reset values asynchronously and no `ready` pulse is produced.

## Timing
- **Latency.** Taking edge 0 as the edge that samples `req`:
  - Mapped access: `ready` is high in cycle `ACCESS_CYCLES+2`.
  - Unmapped access: `ready` is high in cycle 1.
- **Grant.** `bg[dev]` is high for exactly `ACCESS_CYCLES` consecutive cycles.
- **Bus stability.** `addr`/`ctrl` are stable from SETUP through the last ACCESS cycle.
- **Throughput.** Minimum request-to-request spacing is `ACCESS_CYCLES+3` cycles (IDLE, SETUP, ACCESS×N, DONE).
- **Output style.** All outputs are registered, except `data`, whose tri-state enable is decoded from registered state.

## Structure
- **`param.v` additions.** Add `IO_DEV_SEL_LSB`, `IO_DEV_SEL_W` and `IO_N_DEV` defaults, plus the state encodings `IO_MST_IDLE`/`SETUP`/`ACCESS`/`DONE` (2 bits). Reuse the existing `IO_BUS_*` and `IO_CTRL_*` defines.
- **Sub-module `io_bus_master_decode`.** Combinational: address → `dev` index, `valid` flag, and one-hot `bg` vector. It is instantiated once in the master and is reusable by the bus arbiter.

## Test plan
- **Write, device 1.** `cpu_addr`=0x0000_1000, `wdata`=0x0000_00A5, `ACCESS_CYCLES`=1 → `data`=0xA5 in cycles 1–2; `bg`=4'b0010 only in cycle 2; device model latches 0xA5; `ready`=1 in cycle 3; `err`=0.
- **Read, device 0.** Model drives 0x0000_1234 when granted, `cpu_addr`=0x0000_0000 → `data` Z from the master throughout; `rdata`=0x1234 with `ready` in cycle 3.
- **Unmapped address.** `cpu_addr`=0x0000_7000 → `ready`=1 and `err`=1 in cycle 1; `bg` never asserted; `rdata`=0.
- **Long access and back-to-back requests.** `ACCESS_CYCLES`=3, two reads with `req` held high → `bg` high for 3 cycles each; `ready` in cycles 5 and 11; second request ignored until IDLE.
- **Reset mid-access.** `rst_n` pulled low during ACCESS of a write → `bg`=0, `data`=Z, `busy`=0 before the next edge; no `ready`; the next request after reset completes normally.

Source files
------------

// File: rtl/io_bus_master_pkg.sv
// IO bus constants, master state encodings and the ctrl-word helper shared by master, decoder and arbiter.
// Pure declarations: no latency, no flow control.
package io_bus_master_pkg;

    localparam int IO_BUS_WIDTH_ADDR = 32;
    localparam int IO_BUS_WIDTH_DATA = 32;
    localparam int IO_BUS_WIDTH_CTRL = 4;
    localparam int IO_BUS_CTRL_WE    = 0;

    localparam logic IO_CTRL_WRITE = 1'b1;
    localparam logic IO_CTRL_READ  = 1'b0;

    localparam int IO_DEV_SEL_LSB = 12;
    localparam int IO_DEV_SEL_W   = 4;
    localparam int IO_N_DEV       = 4;

    typedef enum logic [1:0] {
        IO_MST_IDLE   = 2'd0,
        IO_MST_SETUP  = 2'd1,
        IO_MST_ACCESS = 2'd2,
        IO_MST_DONE   = 2'd3
    } io_mst_state_e;

    typedef logic [IO_BUS_WIDTH_ADDR-1:0] io_addr_t;
    typedef logic [IO_BUS_WIDTH_DATA-1:0] io_data_t;
    typedef logic [IO_BUS_WIDTH_CTRL-1:0] io_ctrl_t;

    // CPU request as captured in IDLE; held for the whole transfer.
    typedef struct packed {
        logic     we;
        io_addr_t addr;
        io_data_t wdata;
    } io_req_t;

    function automatic io_ctrl_t io_ctrl_word(input logic we);
        io_ctrl_t c;
        c = '0;
        c[IO_BUS_CTRL_WE] = we ? IO_CTRL_WRITE : IO_CTRL_READ;
        return c;
    endfunction

endpackage

// File: rtl/io_bus_master_if.sv
// CPU-side request/completion and IO-bus address/ctrl/grant signals of the bus master.
// The shared tri-state data bus is carried as a separate inout port on the master.
interface io_bus_master_if #(
    parameter int N_DEV = io_bus_master_pkg::IO_N_DEV
) ();
    import io_bus_master_pkg::*;

    logic             req;
    logic             we;
    io_addr_t         cpu_addr;
    io_data_t         wdata;
    logic             ready;
    logic             err;
    io_data_t         rdata;
    logic             busy;

    io_addr_t         addr;
    io_ctrl_t         ctrl;
    logic [N_DEV-1:0] bg;

    modport master (
        input  req, we, cpu_addr, wdata,
        output ready, err, rdata, busy, addr, ctrl, bg
    );

    modport slave (
        output req, we, cpu_addr, wdata,
        input  ready, err, rdata, busy, addr, ctrl, bg
    );

endinterface

// File: rtl/io_bus_master_decode.sv
// Address -> device index, mapped flag and one-hot grant vector.
// Purely combinational (zero latency); no flow control.
module io_bus_master_decode
    import io_bus_master_pkg::*;
#(
    parameter int N_DEV       = IO_N_DEV,
    parameter int DEV_SEL_LSB = IO_DEV_SEL_LSB,
    parameter int DEV_SEL_W   = IO_DEV_SEL_W
) (
    input  io_addr_t             addr,
    output logic [DEV_SEL_W-1:0] dev,
    output logic                 valid,
    output logic [N_DEV-1:0]     bg
);

    // Only the select field matters; the rest of the address belongs to the device.
    io_addr_t unused_addr;
    assign unused_addr = addr;

    always_comb begin
        dev   = addr[DEV_SEL_LSB +: DEV_SEL_W];
        valid = (int'(dev) < N_DEV);
        bg    = '0;
        for (int i = 0; i < N_DEV; i++) begin
            bg[i] = valid && (int'(dev) == i);
        end
    end

endmodule

// File: rtl/io_bus_master.sv
// CPU-side IO bus initiator: decode, SETUP, ACCESS x ACCESS_CYCLES, DONE with a one-cycle ready pulse.
// Latency ACCESS_CYCLES+2 (mapped) or 1 (unmapped); req is ignored while busy, no other backpressure.
module io_bus_master
    import io_bus_master_pkg::*;
#(
    parameter int N_DEV         = IO_N_DEV,
    parameter int DEV_SEL_LSB   = IO_DEV_SEL_LSB,
    parameter int DEV_SEL_W     = IO_DEV_SEL_W,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    io_bus_master_if.master        bus,
    inout  wire  [IO_BUS_WIDTH_DATA-1:0] data
);

    if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
        $error("io_bus_master: ACCESS_CYCLES must be 1..15");
    end

    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    io_mst_state_e        state;
    io_req_t              req_q;
    logic [N_DEV-1:0]     grant_q;
    logic [3:0]           cnt;
    logic                 drive_en;

    logic [DEV_SEL_W-1:0] dec_dev;
    logic                 dec_valid;
    logic [N_DEV-1:0]     dec_bg;

    io_bus_master_decode #(
        .N_DEV       (N_DEV),
        .DEV_SEL_LSB (DEV_SEL_LSB),
        .DEV_SEL_W   (DEV_SEL_W)
    ) u_decode (
        .addr  (bus.cpu_addr),
        .dev   (dec_dev),
        .valid (dec_valid),
        .bg    (dec_bg)
    );

    // The grant vector already encodes the selected device.
    logic [DEV_SEL_W-1:0] unused_dev;
    assign unused_dev = dec_dev;

    // Enable comes straight from registered state so the bus is released the cycle DONE starts.
    assign drive_en = req_q.we && ((state == IO_MST_SETUP) || (state == IO_MST_ACCESS));
    assign data     = drive_en ? req_q.wdata : {IO_BUS_WIDTH_DATA{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IO_MST_IDLE;
            req_q     <= '0;
            grant_q   <= '0;
            cnt       <= '0;
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= '0;
            bus.busy  <= 1'b0;
            bus.addr  <= '0;
            bus.ctrl  <= io_ctrl_word(IO_CTRL_READ);
            bus.bg    <= '0;
        end else begin
            case (state)
                IO_MST_IDLE: begin
                    if (bus.req) begin
                        req_q.we    <= bus.we;
                        req_q.addr  <= bus.cpu_addr;
                        req_q.wdata <= bus.wdata;
                        bus.busy    <= 1'b1;
                        if (dec_valid) begin
                            grant_q  <= dec_bg;
                            bus.addr <= bus.cpu_addr;
                            bus.ctrl <= io_ctrl_word(bus.we);
                            state    <= IO_MST_SETUP;
                        end else begin
                            // Unmapped: complete at once with err, never touch the bus.
                            bus.err   <= 1'b1;
                            bus.ready <= 1'b1;
                            if (!bus.we) begin
                                bus.rdata <= '0;
                            end
                            state <= IO_MST_DONE;
                        end
                    end
                end

                IO_MST_SETUP: begin
                    bus.bg <= grant_q;
                    cnt    <= CNT_LOAD;
                    state  <= IO_MST_ACCESS;
                end

                IO_MST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Device latches write data on this same edge.
                        if (!req_q.we) begin
                            bus.rdata <= data;
                        end
                        bus.bg    <= '0;
                        bus.ctrl  <= io_ctrl_word(IO_CTRL_READ);
                        bus.ready <= 1'b1;
                        state     <= IO_MST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                IO_MST_DONE: begin
                    bus.ready <= 1'b0;
                    bus.err   <= 1'b0;
                    bus.busy  <= 1'b0;
                    state     <= IO_MST_IDLE;
                end

                default: begin
                    state <= IO_MST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: one instance with ACCESS_CYCLES=1, one with ACCESS_CYCLES=3.
// Device models drive read data when granted and latch write data at the end of a granted write.
module tb_io_bus_master;
    import io_bus_master_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    io_bus_master_if #(.N_DEV(4)) bus1 ();
    io_bus_master_if #(.N_DEV(4)) bus3 ();
    wire [31:0] data1;
    wire [31:0] data3;

    io_bus_master #(
        .N_DEV(4), .DEV_SEL_LSB(12), .DEV_SEL_W(4), .ACCESS_CYCLES(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .data(data1)
    );

    io_bus_master #(
        .N_DEV(4), .DEV_SEL_LSB(12), .DEV_SEL_W(4), .ACCESS_CYCLES(3)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .data(data3)
    );

    function automatic logic [31:0] dev_rd_val(input logic [3:0] g);
        case (g)
            4'b0001: return 32'h0000_1234;
            4'b0010: return 32'hBEEF_0001;
            4'b0100: return 32'h5A5A_0002;
            4'b1000: return 32'h0000_0003;
            default: return 32'h0;
        endcase
    endfunction

    assign data1 = (bus1.bg != 4'b0 && bus1.ctrl[IO_BUS_CTRL_WE] == IO_CTRL_READ) ? dev_rd_val(bus1.bg) : 32'bz;
    assign data3 = (bus3.bg != 4'b0 && bus3.ctrl[IO_BUS_CTRL_WE] == IO_CTRL_READ) ? dev_rd_val(bus3.bg) : 32'bz;

    logic [31:0] dev1_reg = 32'h0;
    always @(posedge clk) begin
        if (bus1.bg[1] && bus1.ctrl[IO_BUS_CTRL_WE] == IO_CTRL_WRITE) dev1_reg <= data1;
    end

    function automatic logic hiz(input logic [31:0] v);
        return (v === 32'bz) || (v === 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_bg [12] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0};
    logic       exp_rdy[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_bsy[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        bus1.req = 1'b0; bus1.we = 1'b0; bus1.cpu_addr = '0; bus1.wdata = '0;
        bus3.req = 1'b0; bus3.we = 1'b0; bus3.cpu_addr = '0; bus3.wdata = '0;

        // Reset values
        #1 rst_n = 1'b0;
        tick();
        chk("rst_ready", bus1.ready, 0);
        chk("rst_err",   bus1.err,   0);
        chk("rst_rdata", bus1.rdata, 0);
        chk("rst_busy",  bus1.busy,  0);
        chk("rst_addr",  bus1.addr,  0);
        chk("rst_ctrl",  bus1.ctrl,  0);
        chk("rst_bg",    bus1.bg,    0);
        chk("rst_data_z", hiz(data1), 1);
        chk("rst3_busy", bus3.busy,  0);
        chk("rst3_bg",   bus3.bg,    0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Read device 0 (wdata garbage must never reach the bus)
        bus1.we = 1'b0; bus1.cpu_addr = 32'h0000_0000; bus1.wdata = 32'hDEAD_BEEF; bus1.req = 1'b1;
        tick(); bus1.req = 1'b0;
        chk("rd_c1_busy",  bus1.busy, 1);
        chk("rd_c1_ctrl",  bus1.ctrl, 4'b0000);
        chk("rd_c1_bg",    bus1.bg,   0);
        chk("rd_c1_z",     hiz(data1), 1);
        chk("rd_c1_ready", bus1.ready, 0);
        tick();
        chk("rd_c2_bg",    bus1.bg,   4'b0001);
        chk("rd_c2_data",  data1,     32'h0000_1234);
        chk("rd_c2_ready", bus1.ready, 0);
        tick();
        chk("rd_c3_ready", bus1.ready, 1);
        chk("rd_c3_err",   bus1.err,   0);
        chk("rd_c3_rdata", bus1.rdata, 32'h0000_1234);
        chk("rd_c3_bg",    bus1.bg,    0);
        tick();
        chk("rd_c4_ready", bus1.ready, 0);
        chk("rd_c4_busy",  bus1.busy,  0);
        chk("rd_c4_rdata", bus1.rdata, 32'h0000_1234);

        // Write device 1
        bus1.we = 1'b1; bus1.cpu_addr = 32'h0000_1000; bus1.wdata = 32'h0000_00A5; bus1.req = 1'b1;
        tick(); bus1.req = 1'b0;
        chk("wr_c1_data", data1,     32'h0000_00A5);
        chk("wr_c1_bg",   bus1.bg,   0);
        chk("wr_c1_ctrl", bus1.ctrl, 4'b0001);
        chk("wr_c1_addr", bus1.addr, 32'h0000_1000);
        tick();
        chk("wr_c2_bg",    bus1.bg, 4'b0010);
        chk("wr_c2_data",  data1,   32'h0000_00A5);
        chk("wr_c2_ready", bus1.ready, 0);
        tick();
        chk("wr_c3_ready", bus1.ready, 1);
        chk("wr_c3_err",   bus1.err,   0);
        chk("wr_c3_bg",    bus1.bg,    0);
        chk("wr_c3_z",     hiz(data1), 1);
        chk("wr_dev_latch", dev1_reg,  32'h0000_00A5);
        chk("wr_rdata_kept", bus1.rdata, 32'h0000_1234);
        tick();
        chk("wr_c4_ready", bus1.ready, 0);

        // Unmapped write: err completion, rdata untouched
        bus1.we = 1'b1; bus1.cpu_addr = 32'h0000_8000; bus1.wdata = 32'h0000_0055; bus1.req = 1'b1;
        tick(); bus1.req = 1'b0;
        chk("uw_c1_ready", bus1.ready, 1);
        chk("uw_c1_err",   bus1.err,   1);
        chk("uw_c1_bg",    bus1.bg,    0);
        chk("uw_c1_z",     hiz(data1), 1);
        chk("uw_c1_rdata", bus1.rdata, 32'h0000_1234);
        tick();
        chk("uw_c2_ready", bus1.ready, 0);
        chk("uw_c2_err",   bus1.err,   0);
        chk("uw_c2_busy",  bus1.busy,  0);

        // Unmapped read: rdata forced to 0
        bus1.we = 1'b0; bus1.cpu_addr = 32'h0000_7000; bus1.req = 1'b1;
        tick(); bus1.req = 1'b0;
        chk("ur_c1_ready", bus1.ready, 1);
        chk("ur_c1_err",   bus1.err,   1);
        chk("ur_c1_rdata", bus1.rdata, 0);
        chk("ur_c1_bg",    bus1.bg,    0);
        tick();
        chk("ur_c2_err",   bus1.err,   0);
        chk("ur_c2_busy",  bus1.busy,  0);

        // Back-to-back reads, ACCESS_CYCLES=3, req held; cpu_addr changes while busy
        bus3.we = 1'b0; bus3.cpu_addr = 32'h0000_2000; bus3.req = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            chk($sformatf("b2b_bg_c%0d", c),    bus3.bg,    exp_bg[c]);
            chk($sformatf("b2b_ready_c%0d", c), bus3.ready, exp_rdy[c]);
            chk($sformatf("b2b_busy_c%0d", c),  bus3.busy,  exp_bsy[c]);
            if (c >= 2 && c <= 4) chk($sformatf("b2b_addr_c%0d", c), bus3.addr, 32'h0000_2000);
            if (c >= 8 && c <= 10) chk($sformatf("b2b_addr_c%0d", c), bus3.addr, 32'h0000_3000);
            if (c == 5) chk("b2b_rdata_1", bus3.rdata, 32'h5A5A_0002);
            if (c == 11) chk("b2b_rdata_2", bus3.rdata, 32'h0000_0003);
            if (c == 1) bus3.cpu_addr = 32'h0000_3000;
            if (c == 7) bus3.req = 1'b0;
        end
        tick();
        chk("b2b_c12_ready", bus3.ready, 0);
        chk("b2b_c12_busy",  bus3.busy,  0);

        // Reset during ACCESS of a write
        bus3.we = 1'b1; bus3.cpu_addr = 32'h0000_1000; bus3.wdata = 32'h0000_0077; bus3.req = 1'b1;
        tick(); bus3.req = 1'b0;
        tick();
        chk("rma_pre_bg",   bus3.bg, 4'b0010);
        chk("rma_pre_data", data3,   32'h0000_0077);
        #3 rst_n = 1'b0;
        #1;
        chk("rma_bg",    bus3.bg,    0);
        chk("rma_busy",  bus3.busy,  0);
        chk("rma_z",     hiz(data3), 1);
        chk("rma_ready", bus3.ready, 0);
        chk("rma_ctrl",  bus3.ctrl,  0);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rma_noready_%0d", c), bus3.ready, 0);
        end

        // Next request after reset completes normally
        bus3.we = 1'b0; bus3.cpu_addr = 32'h0000_0000; bus3.req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) bus3.req = 1'b0;
            if (c == 4) chk("rec_c4_ready", bus3.ready, 0);
        end
        chk("rec_c5_ready", bus3.ready, 1);
        chk("rec_c5_rdata", bus3.rdata, 32'h0000_1234);
        chk("rec_c5_err",   bus3.err,   0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
